// File: rtl/irq_pending_4bit.sv
// Interrupt pending tracker: captures 4 request lines into sticky pending bits and
// offers a masked snapshot to a downstream priority encoder until it is acknowledged.
module irq_pending_4bit #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mask_wr,
  input  logic [3:0] mask_in,
  input  logic       ack,
  input  logic [1:0] ack_idx,
  input  logic       ovf_clr,
  output logic [3:0] d,
  output logic       en,
  output logic [3:0] ovf,
  output logic       ack_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] req_q;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [3:0] rise;
  logic [3:0] cap;
  logic [3:0] clr;
  logic [3:0] pending_nxt;
  logic [3:0] ovf_set;
  logic [3:0] d_nxt;
  logic       en_nxt;
  logic       valid_ack;
  logic       invalid_ack;

  assign rise        = req & ~req_q;
  assign cap         = EDGE ? rise : req;
  assign valid_ack   = (state == OFFER) && ack && d[ack_idx];
  assign invalid_ack = (state == OFFER) && ack && !d[ack_idx];
  assign clr         = valid_ack ? (4'b0001 << ack_idx) : 4'b0000;
  // A capture in the same cycle as the clear keeps the bit set.
  assign pending_nxt = (pending & ~clr) | cap;
  assign ovf_set     = cap & pending & ~clr;

  // The snapshot is frozen while offered; only a valid acknowledge releases it.
  always_comb begin
    state_nxt = state;
    d_nxt     = d;
    en_nxt    = en;
    case (state)
      IDLE: begin
        d_nxt  = 4'b0000;
        en_nxt = 1'b0;
        if (|(pending & mask)) begin
          state_nxt = OFFER;
          d_nxt     = pending & mask;
          en_nxt    = 1'b1;
        end
      end
      OFFER: begin
        if (valid_ack) begin
          state_nxt = IDLE;
          d_nxt     = 4'b0000;
          en_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        d_nxt     = 4'b0000;
        en_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= 4'b0000;
      pending <= 4'b0000;
      mask    <= 4'b1111;
      d       <= 4'b0000;
      en      <= 1'b0;
      ovf     <= 4'b0000;
      ack_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      req_q   <= req;
      pending <= pending_nxt;
      if (mask_wr) mask <= mask_in;
      d       <= d_nxt;
      en      <= en_nxt;
      ovf     <= (ovf_clr ? 4'b0000 : ovf) | ovf_set;
      ack_err <= invalid_ack;
    end
  end

endmodule

// File: tb/tb_irq_pending_4bit.sv
// Bench for irq_pending_4bit: edge- and level-capture instances share stimulus and are
// compared each cycle against a per-source reference model through an expected queue.
module tb_irq_pending_4bit;

  localparam int W = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       mask_wr = 1'b0;
  logic [3:0] mask_in = 4'b0000;
  logic       ack = 1'b0;
  logic [1:0] ack_idx = 2'b00;
  logic       ovf_clr = 1'b0;
  logic [3:0] d_e, ovf_e, d_l, ovf_l;
  logic       en_e, ack_err_e, en_l, ack_err_l;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  // model state, index 0 = edge capture, 1 = level capture
  bit m_reqq[2][4];
  bit m_pend[2][4];
  bit m_mask[2][4];
  bit m_ovf[2][4];
  bit m_snap[2][4];
  bit m_off[2];
  bit m_err[2];

  always #5 clk = ~clk;

  irq_pending_4bit #(.EDGE(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
    .ack(ack), .ack_idx(ack_idx), .ovf_clr(ovf_clr),
    .d(d_e), .en(en_e), .ovf(ovf_e), .ack_err(ack_err_e)
  );

  irq_pending_4bit #(.EDGE(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
    .ack(ack), .ack_idx(ack_idx), .ovf_clr(ovf_clr),
    .d(d_l), .en(en_l), .ovf(ovf_l), .ack_err(ack_err_l)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_off[k] = 1'b0;
      m_err[k] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_reqq[k][i] = 1'b0;
        m_pend[k][i] = 1'b0;
        m_mask[k][i] = 1'b1;
        m_ovf[k][i]  = 1'b0;
        m_snap[k][i] = 1'b0;
      end
    end
  endtask

  // One clock edge of the rules, applied source by source from the current inputs.
  task automatic model_step(input int k);
    bit cap[4];
    bit clr[4];
    bit nxt_pend[4];
    bit vack, iack, any;
    int ai;
    ai   = int'(ack_idx);
    vack = m_off[k] && ack && m_snap[k][ai];
    iack = m_off[k] && ack && !m_snap[k][ai];
    any  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cap[i]      = (k == 0) ? (req[i] && !m_reqq[k][i]) : req[i];
      clr[i]      = vack && (i == ai);
      nxt_pend[i] = (m_pend[k][i] && !clr[i]) || cap[i];
      if (m_pend[k][i] && m_mask[k][i]) any = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (ovf_clr) m_ovf[k][i] = 1'b0;
      if (cap[i] && m_pend[k][i] && !clr[i]) m_ovf[k][i] = 1'b1;
    end
    if (m_off[k]) begin
      if (vack) begin
        m_off[k] = 1'b0;
        for (int i = 0; i < 4; i++) m_snap[k][i] = 1'b0;
      end
    end else if (any) begin
      m_off[k] = 1'b1;
      for (int i = 0; i < 4; i++) m_snap[k][i] = m_pend[k][i] && m_mask[k][i];
    end
    m_err[k] = iack;
    for (int i = 0; i < 4; i++) begin
      m_reqq[k][i] = req[i];
      m_pend[k][i] = nxt_pend[i];
      if (mask_wr) m_mask[k][i] = mask_in[i];
    end
  endtask

  function automatic logic [9:0] pack(input int k);
    logic [9:0] v;
    v[9] = m_err[k];
    v[4] = m_off[k];
    for (int i = 0; i < 4; i++) begin
      v[i]     = m_snap[k][i];
      v[5 + i] = m_ovf[k][i];
    end
    return v;
  endfunction

  task automatic cycle(input logic rn, input logic [3:0] r, input logic mw, input logic [3:0] mi,
                       input logic a, input logic [1:0] ai, input logic oc);
    @(negedge clk);
    rst_n = rn; req = r; mask_wr = mw; mask_in = mi; ack = a; ack_idx = ai; ovf_clr = oc;
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    exp_q.push_back({pack(1), pack(0)});
  endtask

  task automatic tick(input logic [3:0] r);
    cycle(1'b1, r, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic ack_c(input logic [3:0] r, input logic [1:0] idx);
    cycle(1'b1, r, 1'b0, 4'b0000, 1'b1, idx, 1'b0);
  endtask

  // Reset dropped between clock edges; outputs must clear before the next edge.
  task automatic async_reset(input logic [3:0] r);
    @(negedge clk);
    req = r; mask_wr = 1'b0; ack = 1'b0; ovf_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_d_edge", {4'b0, d_e}, 8'h00);
    check("async_en_edge", {7'b0, en_e}, 8'h00);
    check("async_ovf_edge", {4'b0, ovf_e}, 8'h00);
    check("async_d_level", {4'b0, d_l}, 8'h00);
    check("async_en_level", {7'b0, en_l}, 8'h00);
    model_reset();
    exp_q.push_back({pack(1), pack(0)});
  endtask

  // Monitor: the DUT presents registered outputs every cycle; compare against the queue head.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("edge_d", {4'b0, d_e}, {4'b0, e[3:0]});
        check("edge_en", {7'b0, en_e}, {7'b0, e[4]});
        check("edge_ovf", {4'b0, ovf_e}, {4'b0, e[8:5]});
        check("edge_ack_err", {7'b0, ack_err_e}, {7'b0, e[9]});
        check("level_d", {4'b0, d_l}, {4'b0, e[13:10]});
        check("level_en", {7'b0, en_l}, {7'b0, e[14]});
        check("level_ovf", {4'b0, ovf_l}, {4'b0, e[18:15]});
        check("level_ack_err", {7'b0, ack_err_l}, {7'b0, e[19]});
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic [1:0] ai;
    model_reset();
    #3;
    check("reset_d", {4'b0, d_e}, 8'h00);
    check("reset_en", {7'b0, en_e}, 8'h00);
    check("reset_ovf", {4'b0, ovf_e}, 8'h00);
    check("reset_ack_err", {7'b0, ack_err_e}, 8'h00);
    cycle(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0);
    tick(4'b0000);
    tick(4'b0000);

    // single source offer and acknowledge
    tick(4'b1000);
    tick(4'b0000);
    tick(4'b0000);
    ack_c(4'b0000, 2'd3);
    tick(4'b0000);
    tick(4'b0000);

    // second request queued behind an outstanding offer
    tick(4'b0100);
    tick(4'b0000);
    tick(4'b0010);
    tick(4'b0000);
    ack_c(4'b0000, 2'd2);
    tick(4'b0000);
    tick(4'b0000);
    ack_c(4'b0000, 2'd1);
    tick(4'b0000);

    // masked source held pending until unmasked
    cycle(1'b1, 4'b0000, 1'b1, 4'b1110, 1'b0, 2'b00, 1'b0);
    tick(4'b0001);
    tick(4'b0000);
    tick(4'b0000);
    cycle(1'b1, 4'b0000, 1'b1, 4'b1111, 1'b0, 2'b00, 1'b0);
    tick(4'b0000);
    tick(4'b0000);
    ack_c(4'b0000, 2'd0);
    tick(4'b0000);

    // invalid acknowledge, overflow, overflow clear
    tick(4'b0100);
    tick(4'b0000);
    tick(4'b0000);
    ack_c(4'b0000, 2'd0);
    tick(4'b0000);
    tick(4'b0100);
    tick(4'b0000);
    cycle(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b1);
    tick(4'b0000);
    // overflow raised in the same cycle as a clear wins for its bit
    cycle(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b1);
    ack_c(4'b0000, 2'd2);
    tick(4'b0000);
    tick(4'b0000);

    // reset during an offer, request held across release
    tick(4'b1010);
    tick(4'b0000);
    tick(4'b0000);
    async_reset(4'b0001);
    cycle(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0);
    tick(4'b0001);
    tick(4'b0001);
    tick(4'b0001);
    ack_c(4'b0001, 2'd0);
    tick(4'b0001);
    tick(4'b0001);
    ack_c(4'b0001, 2'd0);
    tick(4'b0001);
    tick(4'b0001);
    ack_c(4'b0000, 2'd0);
    tick(4'b0000);
    tick(4'b0000);
    cycle(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset(4'($urandom_range(0, 15)));
        cycle(1'b0, 4'($urandom_range(0, 15)), 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0);
      end else begin
        r  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        ai = 2'($urandom_range(0, 3));
        cycle(1'b1, r,
              ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 2) == 0), ai,
              ($urandom_range(0, 19) == 0));
      end
    end

    tick(4'b0000);
    tick(4'b0000);
    @(posedge clk);
    #3;
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
